// File: rtl/synth_aux_peripherals.sv
// Auxiliary synth peripherals: retriggerable exponential decay envelope,
// 32-bit Galois LFSR noise source and a 4x4 multiplexed LED scanner.
module synth_aux_peripherals #(
  parameter int unsigned DECAY_SHIFT   = 8,
  parameter int unsigned SCAN_DIV_BITS = 12,
  parameter logic [31:0] NOISE_SEED    = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic [15:0] decay_time,
  output logic [15:0] decayout,
  output logic [15:0] audio_out,
  input  logic [15:0] ledbits,
  output logic [3:0]  aled,
  output logic [3:0]  kled_tri
);

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [SCAN_DIV_BITS-1:0] DIV_ONE = {{(SCAN_DIV_BITS-1){1'b0}}, 1'b1};

  logic [15:0]              env_q, env_d;
  logic [15:0]              pre_q, pre_d;
  logic [31:0]              lfsr_q, lfsr_d;
  logic [SCAN_DIV_BITS-1:0] div_q, div_d;
  logic [1:0]               row_q, row_d;
  logic [3:0]               aled_q, aled_d;
  logic [3:0]               kled_q, kled_d;

  // Envelope: prescaler matches decay_time once per step, then env decays
  // by env>>DECAY_SHIFT plus one so it always reaches zero.
  always_comb begin
    env_d = env_q;
    pre_d = pre_q;
    if (trigger) begin
      env_d = '1;
      pre_d = '0;
    end else if (pre_q != decay_time) begin
      pre_d = pre_q + 16'd1;
    end else begin
      pre_d = '0;
      if (env_q != '0) begin
        env_d = env_q - (env_q >> DECAY_SHIFT) - 16'd1;
      end
    end
  end

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ LFSR_MASK;
    end
  end

  // Row outputs and ledbits are only refreshed at divider terminal count.
  always_comb begin
    div_d  = div_q + DIV_ONE;
    row_d  = row_q;
    aled_d = aled_q;
    kled_d = kled_q;
    if (div_q == '1) begin
      kled_d = 4'b0001 << row_q;
      aled_d = ~ledbits[{row_q, 2'b00} +: 4];
      row_d  = row_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      env_q  <= '0;
      pre_q  <= '0;
      lfsr_q <= NOISE_SEED;
      div_q  <= '0;
      row_q  <= '0;
      aled_q <= '1;
      kled_q <= '0;
    end else begin
      env_q  <= env_d;
      pre_q  <= pre_d;
      lfsr_q <= lfsr_d;
      div_q  <= div_d;
      row_q  <= row_d;
      aled_q <= aled_d;
      kled_q <= kled_d;
    end
  end

  assign decayout  = env_q;
  assign audio_out = lfsr_q[15:0];
  assign aled      = aled_q;
  assign kled_tri  = kled_q;

endmodule

// File: tb/tb_synth_aux_peripherals.sv
// Self-checking bench for synth_aux_peripherals: directed checks plus
// randomized stimulus against a cycle-count based reference model.
module tb_synth_aux_peripherals;

  localparam int unsigned SDB    = 2;
  localparam int unsigned PERIOD = 1 << SDB;
  localparam logic [31:0] SEED   = 32'h0000_0001;
  localparam logic [31:0] MASK   = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic [15:0] decay_time;
  logic [15:0] decayout;
  logic [15:0] audio_out;
  logic [15:0] ledbits;
  logic [3:0]  aled;
  logic [3:0]  kled_tri;

  synth_aux_peripherals #(
    .DECAY_SHIFT  (8),
    .SCAN_DIV_BITS(SDB),
    .NOISE_SEED   (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .decay_time(decay_time),
    .decayout  (decayout),
    .audio_out (audio_out),
    .ledbits   (ledbits),
    .aled      (aled),
    .kled_tri  (kled_tri)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference state: envelope, step counter, LFSR, clocks since reset.
  logic [15:0] m_env;
  logic [15:0] m_cnt;
  logic [31:0] m_lfsr;
  int unsigned m_cyc;
  logic [3:0]  m_aled;
  logic [3:0]  m_kled;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advances the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int unsigned row;
    if (rst) begin
      m_env  = 16'h0000;
      m_cnt  = 16'h0000;
      m_lfsr = SEED;
      m_cyc  = 0;
      m_aled = 4'hF;
      m_kled = 4'h0;
    end else begin
      if (trigger) begin
        m_env = 16'hFFFF;
        m_cnt = 16'h0000;
      end else if (m_cnt == decay_time) begin
        m_cnt = 16'h0000;
        if (m_env != 0) m_env = 16'(int'(m_env) - int'(m_env) / 256 - 1);
      end else begin
        m_cnt = 16'(int'(m_cnt) + 1);
      end
      if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr / 2) ^ MASK;
      else                 m_lfsr = m_lfsr / 2;
      m_cyc++;
      if (m_cyc % PERIOD == 0) begin
        row    = (m_cyc / PERIOD - 1) % 4;
        m_kled = 4'(1 << row);
        m_aled = ~4'((ledbits >> (4 * row)) & 16'hF);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("decayout", decayout, m_env);
    check("audio_out", audio_out, m_lfsr[15:0]);
    check("aled", aled, m_aled);
    check("kled_tri", kled_tri, m_kled);
  endtask

  logic [3:0]  led_a[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0]  led_k[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [15:0] prev;
  int unsigned n;

  initial begin
    rst        = 1'b1;
    trigger    = 1'b1;
    decay_time = 16'd0;
    ledbits    = 16'h0000;

    // Reset wins over trigger
    tick();
    check("rst_env", decayout, 16'h0000);
    check("rst_audio", audio_out, 16'h0001);
    check("rst_aled", aled, 4'hF);
    check("rst_kled", kled_tri, 4'h0);
    rst     = 1'b0;
    trigger = 1'b0;
    tick();
    check("lfsr_1", audio_out, 16'h0003);
    tick();
    check("lfsr_2", audio_out, 16'h0002);

    // Decay at one step per clock
    trigger = 1'b1;
    tick();
    check("dec_ffff", decayout, 16'hFFFF);
    trigger = 1'b0;
    tick();
    check("dec_feff", decayout, 16'hFEFF);
    tick();
    check("dec_fe00", decayout, 16'hFE00);
    n = 0;
    while (decayout != 16'h0000 && n < 4000) begin
      tick();
      n++;
    end
    check("dec_zero", decayout, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("dec_hold0", decayout, 16'h0000);
    end

    // decay_time=2: value changes only every third clock
    decay_time = 16'd2;
    trigger    = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      prev = decayout;
      tick();
      check("dt2_change", 32'(decayout != prev), 32'(i % 3 == 0));
    end

    // Retrigger around half scale
    decay_time = 16'd0;
    n = 0;
    while (decayout > 16'h8000 && n < 1000) begin
      tick();
      n++;
    end
    check("retrig_reach", 32'(decayout <= 16'h8000), 32'd1);
    trigger = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("retrig_hold", decayout, 16'hFFFF);
    end
    trigger = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // Reset mid-decay
    rst = 1'b1;
    tick();
    check("rst_mid", decayout, 16'h0000);
    rst = 1'b0;

    // LED scan with a fixed image
    rst     = 1'b1;
    ledbits = 16'h8421;
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      tick();
      if (c < int'(PERIOD)) begin
        check("led_pre_a", aled, 4'hF);
        check("led_pre_k", kled_tri, 4'h0);
      end else begin
        check("led_a", aled, led_a[(c / PERIOD - 1) % 4]);
        check("led_k", kled_tri, led_k[(c / PERIOD - 1) % 4]);
      end
    end

    // Randomized mix of triggers, decay_time changes, images and resets
    for (int i = 0; i < 20000; i++) begin
      trigger = ($urandom_range(0, 199) < 3);
      if ($urandom_range(0, 499) == 0) decay_time = 16'($urandom_range(0, 3));
      ledbits = 16'($urandom);
      rst     = ($urandom_range(0, 2999) == 0);
      tick();
    end

    // Long noise run, repeated after a second reset
    trigger = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 15000; i++) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
